// File: rtl/shift_subtract_divider.sv
`default_nettype none
// ============================================================================
// Module      : shift_subtract_divider
// Description : Unsigned restoring divider. Retires one quotient bit per
//               ITER cycle, so a divide takes WIDTH+1 cycles from the
//               accepting edge to the done pulse. A zero divisor skips the
//               iteration and publishes a flagged result on the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_subtract_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    // Enough counter bits to index WIDTH iterations (0 .. WIDTH-1).
    localparam int                 CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    // After every restoring step the partial remainder is below the divisor,
    // so its top bit is always zero and only WIDTH bits need to be kept;
    // the extra bit lives only in the shifted/trial datapath below.
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH:0]     w_shift_rem;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_next_rem;
    logic [WIDTH-1:0]   w_next_quo;

    // One restoring step: shift {R,Q} left, trial-subtract D, keep or restore.
    always_comb begin
        w_shift_rem = {r_rem, r_quo[WIDTH-1]};
        w_trial     = w_shift_rem - {1'b0, r_div};
        w_next_rem  = w_trial[WIDTH] ? w_shift_rem[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_next_quo  = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
    end

    // Control FSM, working registers and published results.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= dividend;
                            r_div   <= divisor;
                            r_cnt   <= '0;
                            done    <= 1'b0;
                            r_state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    r_rem <= w_next_rem;
                    r_quo <= w_next_quo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        quotient    <= w_next_quo;
                        remainder   <= w_next_rem;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_subtract_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_subtract_divider
// Description : Directed and exhaustive self-checking bench for the
//               4-bit shift/subtract divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_subtract_divider;

    localparam int WIDTH = 4;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    shift_subtract_divider #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request in the current (IDLE) cycle, wait for done, check the
    // result, latency, busy and output stability, and step into the next IDLE.
    task automatic do_op(input int a, input int b, input int eq, input int er, input int ez);
        int n;
        int exp_lat;
        logic [WIDTH-1:0] old_q;
        old_q    = quotient;
        exp_lat  = (b == 0) ? 1 : WIDTH + 1;
        start    = 1'b1;
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        tick();
        start    = 1'b0;
        // Operands must be ignored once accepted.
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
        n = 1;
        while (!done && n < 20) begin
            chk("busy_iter", busy, 1);
            chk("hold_iter", quotient, old_q);
            tick();
            n++;
        end
        chk("latency", n, exp_lat);
        chk("busy_done", busy, 1);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, ez);
        tick();
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int pulses;
        reset    = 1'b1;
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        tick();
        tick();
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Basic and boundary divides.
        do_op(13, 3, 4, 1, 0);
        do_op(15, 1, 15, 0, 0);
        do_op(3, 7, 0, 3, 0);
        do_op(15, 15, 1, 0, 0);
        do_op(9, 0, 15, 9, 1);
        do_op(8, 2, 4, 0, 0);

        // A start pulsed during ITER must be ignored.
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        tick();
        start = 1'b0;
        tick();
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd2;
        tick();
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("ignored_pulses", pulses, 1);
        chk("ignored_quotient", quotient, 4);
        chk("ignored_remainder", remainder, 1);

        // Reset mid-operation aborts without publishing.
        do_op(15, 1, 15, 0, 0);
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_busy", busy, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("abort_no_done", pulses, 0);
        do_op(14, 4, 3, 2, 0);

        // Exhaustive back-to-back sweep against a reference model.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) do_op(a, b, 15, a, 1);
                else        do_op(a, b, a / b, a % b, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
